miu_arb: RTL

- N-port memory interface unit arbiter.
- Lets NUM_PORTS instruction-unit style requesters share one memory port using the existing req/we/addr/write/read/done handshake.
- Round-robin grant; one outstanding memory transaction at a time.
- Sits between the IU array and the single memory-side MIU interface in mp_system.

---
 rtl/miu_arb_pkg.sv | 33 +++
 rtl/miu_arb_if.sv | 42 ++++
 rtl/miu_arb_rr_pick.sv | 44 ++++
 rtl/miu_arb.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/miu_arb_pkg.sv
// ============================================================================
// Module      : miu_pkg
// Description : Shared types, width defaults and helpers for the MIU arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package miu_pkg;

    localparam int MIU_ADDR_W    = 16;
    localparam int MIU_DATA_W    = 16;
    localparam int MIU_MAX_PORTS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } miu_state_e;

    // Indices at or beyond n yield an all-zero vector.
    function automatic logic [MIU_MAX_PORTS-1:0] onehot(input int unsigned idx,
                                                        input int unsigned n);
        logic [MIU_MAX_PORTS-1:0] v;
        v = '0;
        if ((idx < n) && (idx < MIU_MAX_PORTS)) begin
            v[idx[3:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/miu_arb_if.sv
// ============================================================================
// Module      : miu_arb_if
// Description : Requester-array and memory-side handshake bundle for miu_arb.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface miu_arb_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = miu_pkg::MIU_ADDR_W,
    parameter int DATA_W    = miu_pkg::MIU_DATA_W
);

    logic [NUM_PORTS-1:0]        req;
    logic [NUM_PORTS-1:0]        we;
    logic [NUM_PORTS*ADDR_W-1:0] addr;
    logic [NUM_PORTS*DATA_W-1:0] wdata;
    logic [DATA_W-1:0]           rdata;
    logic [NUM_PORTS-1:0]        done;
    logic [NUM_PORTS-1:0]        err;
    logic                        mem_req;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_write;
    logic [DATA_W-1:0]           mem_read;
    logic                        mem_done;

    // Arbiter view.
    modport slave (
        input  req, we, addr, wdata, mem_read, mem_done,
        output rdata, done, err, mem_req, mem_we, mem_addr, mem_write
    );

    // Environment view: requesters plus memory.
    modport master (
        output req, we, addr, wdata, mem_read, mem_done,
        input  rdata, done, err, mem_req, mem_we, mem_addr, mem_write
    );

endinterface

`default_nettype wire

// File: rtl/miu_arb_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker (double-width mask/priority).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 2
) (
    input  wire logic [NUM_PORTS-1:0] i_cand,
    input  wire logic [IDX_W-1:0]     i_rr_ptr,
    output logic      [IDX_W-1:0]     o_grant,
    output logic                      o_valid
);

    localparam int c_DW   = 2 * NUM_PORTS;
    localparam int c_DW_W = $clog2(c_DW);

    logic [c_DW-1:0]   w_dbl;
    logic [c_DW-1:0]   w_masked;
    logic [c_DW_W-1:0] w_pos;
    logic [c_DW_W-1:0] w_wrap;

    // Masking bits below rr_ptr in the doubled vector makes the lowest set
    // bit the first candidate at or above rr_ptr, wrapping naturally.
    always_comb begin
        w_dbl    = {i_cand, i_cand};
        w_masked = w_dbl & ~((c_DW'(1) << i_rr_ptr) - c_DW'(1));
        w_pos    = '0;
        for (int i = c_DW - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                w_pos = c_DW_W'(i);
            end
        end
        w_wrap  = (w_pos >= c_DW_W'(NUM_PORTS)) ? (w_pos - c_DW_W'(NUM_PORTS)) : w_pos;
        o_grant = IDX_W'(w_wrap);
        o_valid = |i_cand;
    end

endmodule

`default_nettype wire

// File: rtl/miu_arb.sv
// ============================================================================
// Module      : miu_arb
// Description : N-port round-robin arbiter onto one MIU memory port.
//               Define MIU_TIMEOUT_EN to enable the BUSY watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module miu_arb
    import miu_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int ADDR_W      = MIU_ADDR_W,
    parameter int DATA_W      = MIU_DATA_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  wire logic  clk,
    input  wire logic  resetN,
    miu_arb_if.slave   bus
);

    localparam int c_IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    miu_state_e           r_state;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic [c_IDX_W-1:0]   r_grant;
    logic [NUM_PORTS-1:0] r_last_mask;
    logic [NUM_PORTS-1:0] r_done;
    logic                 r_mem_req;
    logic                 r_mem_we;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [DATA_W-1:0]    r_mem_write;
    logic [DATA_W-1:0]    r_rdata;

    logic [NUM_PORTS-1:0] w_cand;
    logic [c_IDX_W-1:0]   w_pick;
    logic                 w_pick_vld;
    logic [c_IDX_W-1:0]   w_rr_next;
    logic [NUM_PORTS-1:0] w_grant_oh;

`ifdef MIU_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [NUM_PORTS-1:0] r_err;
    logic [c_TMO_W-1:0]   r_tmo_cnt;
    logic                 w_tmo_hit;

    assign w_tmo_hit = ((r_tmo_cnt + c_TMO_W'(1)) == c_TMO_W'(TIMEOUT_CYC));
    assign bus.err   = r_err;
`else
    assign bus.err   = '0;
`endif

    // The just-served port sits out exactly one IDLE cycle.
    assign w_cand     = bus.req & ~r_last_mask;
    assign w_rr_next  = (r_grant == c_IDX_W'(NUM_PORTS - 1)) ? '0 : (r_grant + c_IDX_W'(1));
    assign w_grant_oh = NUM_PORTS'(onehot(32'(r_grant), NUM_PORTS));

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (c_IDX_W)
    ) u_rr_pick (
        .i_cand   (w_cand),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_pick),
        .o_valid  (w_pick_vld)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_last_mask <= '0;
            r_done      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_write <= '0;
            r_rdata     <= '0;
`ifdef MIU_TIMEOUT_EN
            r_err       <= '0;
            r_tmo_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_last_mask <= '0;
                    if (w_pick_vld) begin
                        r_grant     <= w_pick;
                        r_mem_we    <= bus.we[w_pick];
                        r_mem_addr  <= bus.addr[w_pick*ADDR_W +: ADDR_W];
                        r_mem_write <= bus.wdata[w_pick*DATA_W +: DATA_W];
                        r_mem_req   <= 1'b1;
                        r_state     <= BUSY;
`ifdef MIU_TIMEOUT_EN
                        r_tmo_cnt   <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (bus.mem_done) begin
                        r_rdata     <= bus.mem_read;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_write <= '0;
                        r_done      <= w_grant_oh;
                        r_state     <= RESP;
                    end
`ifdef MIU_TIMEOUT_EN
                    else if (w_tmo_hit) begin
                        r_rdata     <= '0;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_write <= '0;
                        r_done      <= w_grant_oh;
                        r_err       <= w_grant_oh;
                        r_state     <= RESP;
                    end else begin
                        r_tmo_cnt   <= r_tmo_cnt + c_TMO_W'(1);
                    end
`endif
                end
                RESP: begin
                    r_done      <= '0;
`ifdef MIU_TIMEOUT_EN
                    r_err       <= '0;
`endif
                    r_rr_ptr    <= w_rr_next;
                    r_last_mask <= w_grant_oh;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rdata     = r_rdata;
    assign bus.done      = r_done;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_write = r_mem_write;

endmodule

`default_nettype wire
